// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with load-use hazard detection.
// Registers the decoded control bits, operands and register fields for the
// EX stage. It inserts a bubble on flush or on a load-use hazard, freezes
// completely on hold, and keeps a saturating count of inserted bubbles.
// Ports:
//   clk, reset                   clock, async active-high reset
//   idValid                      decode stage holds a real instruction
//   regDst..branch, aluOp        decoded control
//   readData1/2, signExtImm,
//   pcPlus4, idRs/idRt/idRd      decode operands and register fields
//   hold, flush                  freeze / squash requests
//   ex*                          registered copies for EX
//   loadUseStall                 combinational; holds PC and IF/ID
//   bubbleCount                  saturating count of inserted bubbles
module id_ex_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        idValid,
    input  logic        regDst,
    input  logic        aluSrc,
    input  logic        memToReg,
    input  logic        regWrite,
    input  logic        memRead,
    input  logic        memWrite,
    input  logic        branch,
    input  logic [2:0]  aluOp,
    input  logic [31:0] readData1,
    input  logic [31:0] readData2,
    input  logic [31:0] signExtImm,
    input  logic [31:0] pcPlus4,
    input  logic [4:0]  idRs,
    input  logic [4:0]  idRt,
    input  logic [4:0]  idRd,
    input  logic        hold,
    input  logic        flush,
    output logic        exRegDst,
    output logic        exAluSrc,
    output logic        exMemToReg,
    output logic        exRegWrite,
    output logic        exMemRead,
    output logic        exMemWrite,
    output logic        exBranch,
    output logic [2:0]  exAluOp,
    output logic [31:0] exData1,
    output logic [31:0] exData2,
    output logic [31:0] exImm,
    output logic [31:0] exPcPlus4,
    output logic [4:0]  exRs,
    output logic [4:0]  exRt,
    output logic [4:0]  exWriteReg,
    output logic        exValid,
    output logic        loadUseStall,
    output logic [15:0] bubbleCount
);

    localparam int unsigned CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic       w_bubble;
    logic [6:0] w_ctrl;
    logic [2:0] w_alu_op;

    // Load in EX whose destination (not $0) is a source of the ID instruction.
    always_comb begin
        loadUseStall = idValid & exValid & exMemRead & (exRt != 5'd0)
                     & ((exRt == idRs) | (exRt == idRt));
    end

    // Invalid decode slots never carry live control into EX.
    always_comb begin
        w_bubble = flush | loadUseStall;
        w_ctrl   = 7'd0;
        w_alu_op = 3'd0;
        if (idValid) begin
            w_ctrl   = {regDst, aluSrc, memToReg, regWrite, memRead, memWrite, branch};
            w_alu_op = aluOp;
        end
    end

    // Pipeline register: hold > bubble (flush or stall) > capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            {exRegDst, exAluSrc, exMemToReg, exRegWrite,
             exMemRead, exMemWrite, exBranch} <= 7'd0;
            exAluOp     <= 3'd0;
            exData1     <= 32'd0;
            exData2     <= 32'd0;
            exImm       <= 32'd0;
            exPcPlus4   <= 32'd0;
            exRs        <= 5'd0;
            exRt        <= 5'd0;
            exWriteReg  <= 5'd0;
            exValid     <= 1'b0;
            bubbleCount <= '0;
        end else if (!hold) begin
            if (w_bubble) begin
                {exRegDst, exAluSrc, exMemToReg, exRegWrite,
                 exMemRead, exMemWrite, exBranch} <= 7'd0;
                exAluOp    <= 3'd0;
                exData1    <= 32'd0;
                exData2    <= 32'd0;
                exImm      <= 32'd0;
                exPcPlus4  <= 32'd0;
                exRs       <= 5'd0;
                exRt       <= 5'd0;
                exWriteReg <= 5'd0;
                exValid    <= 1'b0;
                if (bubbleCount != CNT_MAX) begin
                    bubbleCount <= bubbleCount + CNT_W'(1);
                end
            end else begin
                {exRegDst, exAluSrc, exMemToReg, exRegWrite,
                 exMemRead, exMemWrite, exBranch} <= w_ctrl;
                exAluOp    <= w_alu_op;
                exData1    <= readData1;
                exData2    <= readData2;
                exImm      <= signExtImm;
                exPcPlus4  <= pcPlus4;
                exRs       <= idRs;
                exRt       <= idRt;
                exWriteReg <= regDst ? idRd : idRt;
                exValid    <= idValid;
            end
        end
    end

endmodule
